palindrome_serializer: RTL and testbench
========================================

PALINDROME_SERIALIZER -- requirements
Module: palindrome_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the generated palindrome word; legal range >= 2.
REQ-002 SHALL derive local constant SEED_W = (DATA_WIDTH+1)/2, the seed width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port din, input, SEED_W, the seed (lower half of the palindrome).
REQ-006 SHALL have port din_valid, input, 1, seed offered.
REQ-007 SHALL have port din_ready, output, 1, seed can be accepted.
REQ-008 SHALL have port dout, output, 1, the serial palindrome bit, MSB first.
REQ-009 SHALL have port dout_valid, output, 1, dout holds a valid bit.
REQ-010 SHALL have port dout_ready, input, 1, sink accepts the dout bit.
REQ-011 SHALL have port dout_last, output, 1, the current bit is bit 0 of the word.
REQ-012 SHALL have port word, output, DATA_WIDTH, the full palindrome currently being sent.

Function
REQ-013 SHALL form word with word[i] = din[i] for i < SEED_W and word[DATA_WIDTH-1-i] = word[i] for every i; odd widths share the middle bit.
REQ-014 SHALL accept a seed on a clk edge where din_valid && din_ready.
REQ-015 SHALL run FSM IDLE/SEND: IDLE -> SEND on accept; SEND -> IDLE when the last bit transfers with no new accept; SEND -> SEND on the last-bit transfer coinciding with an accept.
REQ-016 SHALL assert din_ready in IDLE, and in SEND only while the bit index is 0 and dout_ready is 1 (zero-bubble back-to-back).
REQ-017 SHALL, on accept, register word and set the bit index to DATA_WIDTH-1; dout_valid rises the cycle after accept (latency 1).
REQ-018 SHALL drive dout = word[index] and dout_valid = 1 throughout SEND.
REQ-019 SHALL decrement the index only on a transfer (dout_valid && dout_ready); dout, word and the index hold while dout_ready is 0.
REQ-020 SHALL assert dout_last exactly when in SEND and index = 0.
REQ-021 SHALL size the index to $clog2(DATA_WIDTH) bits; it never wraps below 0 and is reloaded only by an accept.
REQ-022 SHALL ignore din and din_valid whenever din_ready is 0.
REQ-023 SHALL hold word at its last value in IDLE; dout = 0 in IDLE.

Reset
REQ-024 SHALL, while reset is 1 at a clk edge, enter IDLE, clear word and the index to 0, and drive dout_valid = 0, dout_last = 0, dout = 0.
REQ-025 SHALL drive din_ready = 1 on the first cycle after reset releases.
REQ-026 SHALL abandon any word in progress on reset mid-SEND, emitting no further bits.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, SEND) in shared package palindrome_pkg.
REQ-028 SHALL implement the mirror of REQ-013 in combinational sub-module palindrome_mirror (parameter DATA_WIDTH, seed in, word out).

Verification
REQ-029 SHALL cover DATA_WIDTH=8, seed 4'b1011, dout_ready=1 -> word=8'hDB, dout stream 1,1,0,1,1,0,1,1 over 8 cycles starting the cycle after accept, dout_last on the 8th.
REQ-030 SHALL cover DATA_WIDTH=5, seed 3'b110 -> word=5'b01110, stream 0,1,1,1,0.
REQ-031 SHALL cover backpressure: dout_ready=0 for 3 cycles after the 2nd bit of seed 4'b1011 -> dout holds 1, index holds, stream resumes unchanged.
REQ-032 SHALL cover back-to-back: seeds 4'b1011 then 4'b0001 with din_valid held -> 16 consecutive valid bits 8'hDB then 8'h81, no gap.
REQ-033 SHALL cover reset asserted during bit 4 -> next cycle dout_valid=0, din_ready=1, word=0.
REQ-034 SHALL cover randomized seeds and widths 2..33 -> every word reversed equals itself and its low SEED_W bits equal the seed.

Source files
------------

// File: rtl/palindrome_pkg.sv
// Shared types for the palindrome serializer slice.
package palindrome_pkg;

    // Serializer control states
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/palindrome_mirror.sv
// Combinational mirror: expands a seed (low half) into a full palindrome word.
module palindrome_mirror #(
    parameter int DATA_WIDTH = 32,
    localparam int SEED_W = (DATA_WIDTH + 1) / 2
) (
    input  logic [SEED_W-1:0]     seed,
    output logic [DATA_WIDTH-1:0] word
);

    // Low half copies the seed; high half reflects it (odd widths share the middle bit)
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        if (i < SEED_W) begin : g_low
            assign word[i] = seed[i];
        end else begin : g_high
            assign word[i] = seed[DATA_WIDTH-1-i];
        end
    end

endmodule

// File: rtl/palindrome_serializer.sv
// Accepts a seed, mirrors it into a palindrome word and shifts it out MSB first.
module palindrome_serializer
    import palindrome_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int SEED_W = (DATA_WIDTH + 1) / 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SEED_W-1:0]     din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(DATA_WIDTH - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   word_q;
    logic [DATA_WIDTH-1:0]   mirrored;
    logic                    accept;
    logic                    xfer;
    logic                    at_last;

    palindrome_mirror #(.DATA_WIDTH(DATA_WIDTH)) u_mirror (
        .seed (din),
        .word (mirrored)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, handshakes and serial outputs
    always_comb begin
        state_nxt  = state;
        din_ready  = 1'b0;
        dout       = 1'b0;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        at_last    = (idx == '0);
        xfer       = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                din_ready = 1'b1;
                accept    = din_valid;
                if (accept) state_nxt = SEND;
            end
            SEND: begin
                dout       = word_q[idx];
                dout_valid = 1'b1;
                dout_last  = at_last;
                xfer       = dout_ready;
                // Ready only as the final bit leaves, so the next word follows with no gap
                din_ready  = at_last && dout_ready;
                accept     = din_valid && din_ready;
                if (xfer && at_last && !accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word and bit-index datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            idx    <= '0;
        end else if (accept) begin
            word_q <= mirrored;
            idx    <= TOP_IDX;
        end else if (xfer && !at_last) begin
            idx <= idx - IDX_W'(1);
        end
    end

    assign word = word_q;

endmodule

// File: tb/tb_palindrome_serializer.sv
// Directed bench for palindrome_serializer plus a width sweep of the mirror.
module tb_palindrome_serializer;

    logic        clk = 1'b0;
    logic        reset;

    logic [3:0]  din8;
    logic        dv8, drdy8, do8, dov8, dor8, dl8;
    logic [7:0]  word8;

    logic [2:0]  din5;
    logic        dv5, drdy5, do5, dov5, dor5, dl5;
    logic [4:0]  word5;

    logic [16:0] rseed;
    logic [32:0] mw [2:33];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    palindrome_serializer #(.DATA_WIDTH(8)) u_dut8 (
        .clk        (clk),
        .reset      (reset),
        .din        (din8),
        .din_valid  (dv8),
        .din_ready  (drdy8),
        .dout       (do8),
        .dout_valid (dov8),
        .dout_ready (dor8),
        .dout_last  (dl8),
        .word       (word8)
    );

    palindrome_serializer #(.DATA_WIDTH(5)) u_dut5 (
        .clk        (clk),
        .reset      (reset),
        .din        (din5),
        .din_valid  (dv5),
        .din_ready  (drdy5),
        .dout       (do5),
        .dout_valid (dov5),
        .dout_ready (dor5),
        .dout_last  (dl5),
        .word       (word5)
    );

    for (genvar g = 2; g <= 33; g++) begin : g_m
        localparam int SW = (g + 1) / 2;
        logic [g-1:0] w;
        palindrome_mirror #(.DATA_WIDTH(g)) u_m (
            .seed (rseed[SW-1:0]),
            .word (w)
        );
        assign mw[g] = 33'(w);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  e8;
        logic [4:0]  e5;
        logic [15:0] e16;
        logic [32:0] v, rev, mask;
        int          sw;

        reset = 1'b1;
        din8 = '0; dv8 = 1'b0; dor8 = 1'b1;
        din5 = '0; dv5 = 1'b0; dor5 = 1'b1;
        rseed = '0;
        tick();
        tick();

        chk("rst_dout_valid", 64'(dov8), 64'(0));
        chk("rst_dout_last",  64'(dl8),  64'(0));
        chk("rst_dout",       64'(do8),  64'(0));
        chk("rst_word",       64'(word8), 64'(0));

        reset = 1'b0;
        tick();
        chk("post_rst_din_ready", 64'(drdy8), 64'(1));

        // Width 8, seed 1011, no backpressure; din offered mid-word must be ignored
        e8 = 8'hDB;
        din8 = 4'b1011; dv8 = 1'b1;
        tick();
        din8 = 4'b0000; dv8 = 1'b0;
        chk("w8_word", 64'(word8), 64'(e8));
        for (int k = 0; k < 8; k++) begin
            dv8 = (k >= 1 && k <= 6);
            chk("w8_valid", 64'(dov8), 64'(1));
            chk("w8_bit",   64'(do8),  64'(e8[7-k]));
            chk("w8_last",  64'(dl8),  64'(k == 7));
            if (k == 2) chk("w8_busy_ready", 64'(drdy8), 64'(0));
            tick();
        end
        dv8 = 1'b0;
        chk("w8_idle_valid", 64'(dov8), 64'(0));
        chk("w8_idle_dout",  64'(do8),  64'(0));
        chk("w8_idle_ready", 64'(drdy8), 64'(1));
        chk("w8_word_held",  64'(word8), 64'(e8));

        // Width 5, seed 110
        e5 = 5'b01110;
        din5 = 3'b110; dv5 = 1'b1;
        tick();
        dv5 = 1'b0;
        chk("w5_word", 64'(word5), 64'(e5));
        for (int k = 0; k < 5; k++) begin
            chk("w5_valid", 64'(dov5), 64'(1));
            chk("w5_bit",   64'(do5),  64'(e5[4-k]));
            chk("w5_last",  64'(dl5),  64'(k == 4));
            tick();
        end
        chk("w5_idle_valid", 64'(dov5), 64'(0));

        // Backpressure while the 2nd bit is presented
        din8 = 4'b1011; dv8 = 1'b1;
        tick();
        dv8 = 1'b0;
        chk("bp_bit0", 64'(do8), 64'(1));
        tick();
        dor8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_valid", 64'(dov8), 64'(1));
            chk("bp_hold_bit",   64'(do8),  64'(1));
            chk("bp_hold_ready", 64'(drdy8), 64'(0));
            chk("bp_hold_word",  64'(word8), 64'(e8));
            tick();
        end
        dor8 = 1'b1;
        for (int k = 1; k < 8; k++) begin
            chk("bp_resume_valid", 64'(dov8), 64'(1));
            chk("bp_resume_bit",   64'(do8),  64'(e8[7-k]));
            chk("bp_resume_last",  64'(dl8),  64'(k == 7));
            tick();
        end
        chk("bp_idle_valid", 64'(dov8), 64'(0));

        // Back-to-back words with din_valid held
        e16 = {8'hDB, 8'h81};
        din8 = 4'b1011; dv8 = 1'b1;
        tick();
        din8 = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) begin
                dv8 = 1'b0;
                chk("b2b_word2", 64'(word8), 64'(8'h81));
            end
            if (k == 7) chk("b2b_ready_last", 64'(drdy8), 64'(1));
            chk("b2b_valid", 64'(dov8), 64'(1));
            chk("b2b_bit",   64'(do8),  64'(e16[15-k]));
            chk("b2b_last",  64'(dl8),  64'(k == 7 || k == 15));
            tick();
        end
        chk("b2b_idle_valid", 64'(dov8), 64'(0));

        // Reset mid-word
        din8 = 4'b1011; dv8 = 1'b1;
        tick();
        dv8 = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_valid_before", 64'(dov8), 64'(1));
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(dov8),  64'(0));
        chk("mid_rst_ready", 64'(drdy8), 64'(1));
        chk("mid_rst_word",  64'(word8), 64'(0));
        chk("mid_rst_dout",  64'(do8),   64'(0));
        reset = 1'b0;
        tick();
        chk("mid_after_valid", 64'(dov8), 64'(0));

        // Mirror sweep over widths 2..33 with random seeds
        for (int r = 0; r < 3; r++) begin
            rseed = 17'($urandom);
            #1;
            for (int w = 2; w <= 33; w++) begin
                v = mw[w];
                rev = '0;
                for (int i = 0; i < w; i++) rev[w-1-i] = v[i];
                chk("mirror_reverse", 64'(rev), 64'(v));
                sw = (w + 1) / 2;
                mask = (33'(1) << sw) - 33'(1);
                chk("mirror_seed", 64'(v & mask), 64'(33'(rseed) & mask));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
